// File: rtl/vote_capture_stage.sv
`timescale 1ns/1ps
// TMR capture register stage: votes triplicated data/valid inputs, holds and scrubs
// triplicated state, and tracks per-replica disagreement in a sticky flag set and saturating counter.
module vote_capture_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             validA,
    input  logic             validB,
    input  logic             validC,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic             outValidA,
    output logic             outValidB,
    output logic             outValidC,
    input  logic             errClr,
    output logic [CNT_W-1:0] errCnt,
    output logic [2:0]       errFlag
);

    function automatic logic [WIDTH-1:0] majData(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic majBit(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic [WIDTH-1:0] regA, regB, regC;
    logic             vA, vB, vC;
    logic [WIDTH-1:0] dVoted, dScrub;
    logic             vVoted;
    logic [2:0]       disagree;

    always_comb begin
        dVoted      = majData(inA, inB, inC);
        vVoted      = majBit(validA, validB, validC);
        dScrub      = majData(regA, regB, regC);
        // Data mismatches only count while the voted qualifier says the data is live.
        disagree[0] = (validA != vVoted) | (vVoted & (inA != dVoted));
        disagree[1] = (validB != vVoted) | (vVoted & (inB != dVoted));
        disagree[2] = (validC != vVoted) | (vVoted & (inC != dVoted));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regA <= '0;
            regB <= '0;
            regC <= '0;
            vA   <= 1'b0;
            vB   <= 1'b0;
            vC   <= 1'b0;
        end else begin
            regA <= vVoted ? dVoted : dScrub;
            regB <= vVoted ? dVoted : dScrub;
            regC <= vVoted ? dVoted : dScrub;
            vA   <= vVoted;
            vB   <= vVoted;
            vC   <= vVoted;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            errCnt  <= '0;
            errFlag <= 3'b000;
        end else if (errClr) begin
            errCnt  <= '0;
            errFlag <= 3'b000;
        end else begin
            if (|disagree) errCnt <= satInc(errCnt);
            errFlag <= errFlag | disagree;
        end
    end

    // One voter per output replica so a single voter fault cannot reach all three outputs.
    assign outA      = majData(regA, regB, regC);
    assign outB      = majData(regA, regB, regC);
    assign outC      = majData(regA, regB, regC);
    assign outValidA = majBit(vA, vB, vC);
    assign outValidB = majBit(vA, vB, vC);
    assign outValidC = majBit(vA, vB, vC);

endmodule

// File: tb/tb_vote_capture_stage.sv
`timescale 1ns/1ps
// Directed bench for vote_capture_stage: default instance plus a CNT_W=2 instance for saturation.
module tb_vote_capture_stage;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] inA, inB, inC;
    logic       validA, validB, validC;
    logic       errClr;

    logic [7:0] outA, outB, outC;
    logic       outValidA, outValidB, outValidC;
    logic [7:0] errCnt;
    logic [2:0] errFlag;

    logic [7:0] outA2, outB2, outC2;
    logic       outValidA2, outValidB2, outValidC2;
    logic [1:0] errCnt2;
    logic [2:0] errFlag2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vote_capture_stage #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .inA(inA), .inB(inB), .inC(inC),
        .validA(validA), .validB(validB), .validC(validC),
        .outA(outA), .outB(outB), .outC(outC),
        .outValidA(outValidA), .outValidB(outValidB), .outValidC(outValidC),
        .errClr(errClr), .errCnt(errCnt), .errFlag(errFlag)
    );

    vote_capture_stage #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn),
        .inA(inA), .inB(inB), .inC(inC),
        .validA(validA), .validB(validB), .validC(validC),
        .outA(outA2), .outB(outB2), .outC(outC2),
        .outValidA(outValidA2), .outValidB(outValidB2), .outValidC(outValidC2),
        .errClr(errClr), .errCnt(errCnt2), .errFlag(errFlag2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic va, input logic vb, input logic vc);
        inA = a; inB = b; inC = c;
        validA = va; validB = vb; validC = vc;
    endtask

    initial begin
        rstn = 1'b0;
        errClr = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_out", {8'h0, outA, outB, outC}, 32'h0);
        check("rst_vld", {outValidA, outValidB, outValidC}, 32'h0);
        check("rst_cnt", errCnt, 32'h0);
        check("rst_flag", errFlag, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // All replicas agree
        drive(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1);
        step();
        check("agree_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        check("agree_vld", {outValidA, outValidB, outValidC}, 32'h7);
        check("agree_cnt", errCnt, 32'h0);
        check("agree_flag", errFlag, 32'h0);

        // Replica C corrupted; persists to exercise 2-bit saturation
        inC = 8'hFF;
        step();
        check("cmis_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        check("cmis_cnt", errCnt, 32'h1);
        check("cmis_flag", errFlag, 32'h4);
        check("sat_cnt1", errCnt2, 32'h1);
        step();
        check("sat_cnt2", errCnt2, 32'h2);
        step();
        check("sat_cnt3", errCnt2, 32'h3);
        step();
        check("sat_cnt4", errCnt2, 32'h3);
        step();
        check("sat_cnt5", errCnt2, 32'h3);
        check("nosat_cnt5", errCnt, 32'h5);
        errClr = 1'b1;
        step();
        check("clr_cnt", errCnt, 32'h0);
        check("clr_flag", errFlag, 32'h0);
        check("clr_cnt2", errCnt2, 32'h0);
        check("clr_flag2", errFlag2, 32'h0);
        errClr = 1'b0;
        inC = 8'h5A;
        step();
        check("post_clr_cnt", errCnt, 32'h0);

        // Hold with valid low, then scrub a corrupted regB
        drive(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
        step();
        check("hold_vld", {outValidA, outValidB, outValidC}, 32'h0);
        check("hold_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        @(negedge clk);
        force dut.regB = 8'h00;
        #1;
        check("upset_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        release dut.regB;
        step();
        check("scrub_regB", dut.regB, 32'h5A);
        check("scrub_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        check("scrub_cnt", errCnt, 32'h0);

        // Lone valid on B is outvoted
        drive(8'h5A, 8'hAA, 8'h5A, 1'b0, 1'b1, 1'b0);
        step();
        check("vb_vld", {outValidA, outValidB, outValidC}, 32'h0);
        check("vb_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        check("vb_flag", errFlag, 32'h2);
        check("vb_cnt", errCnt, 32'h1);

        // Asynchronous reset between edges
        drive(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1);
        step();
        check("pre_rst_out", {8'h0, outA, outB, outC}, 32'h005A5A5A);
        #1 rstn = 1'b0;
        #1;
        check("arst_out", {8'h0, outA, outB, outC}, 32'h0);
        check("arst_vld", {outValidA, outValidB, outValidC}, 32'h0);
        check("arst_cnt", errCnt, 32'h0);
        check("arst_flag", errFlag, 32'h0);
        #1 rstn = 1'b1;
        drive(8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1);
        step();
        check("rel_out", {8'h0, outA, outB, outC}, 32'h003C3C3C);
        check("rel_vld", {outValidA, outValidB, outValidC}, 32'h7);
        check("rel_cnt", errCnt, 32'h0);

        // All three disagree: bitwise majority of 0F/33/55 is 17
        drive(8'h0F, 8'h33, 8'h55, 1'b1, 1'b1, 1'b1);
        step();
        check("tri_out", {8'h0, outA, outB, outC}, 32'h00171717);
        check("tri_flag", errFlag, 32'h7);
        check("tri_cnt", errCnt, 32'h1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vote_capture_stage.md
VOTE_CAPTURE_STAGE -- requirements
Module: vote_capture_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per replica.
REQ-002 The block SHALL have parameter CNT_W, default 8: error counter width.
REQ-003 The block SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-004 The block SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have ports inA/inB/inC, input, WIDTH: triplicated data from the upstream combinational stage.
REQ-006 The block SHALL have ports validA/validB/validC, input, 1: triplicated qualifier for inA/inB/inC.
REQ-007 The block SHALL have ports outA/outB/outC, output, WIDTH: triplicated voted registered data.
REQ-008 The block SHALL have ports outValidA/outValidB/outValidC, output, 1: triplicated output qualifier.
REQ-009 The block SHALL have port errClr, input, 1: synchronous clear of errCnt and errFlag.
REQ-010 The block SHALL have port errCnt, output, CNT_W: saturating count of cycles with any replica disagreement.
REQ-011 The block SHALL have port errFlag, output, 3: sticky per-replica disagreement flags, bit0=A, bit1=B, bit2=C.

Function
REQ-012 Input voting SHALL form dVoted = bitwise majority(inA,inB,inC) and vVoted = majority(validA,validB,validC).
REQ-013 Three data registers regA/regB/regC SHALL each load dVoted on the clock edge when vVoted=1.
REQ-014 When vVoted=0, each regX SHALL load bitwise majority(regA,regB,regC) (scrubbing); data is held but single upsets are corrected.
REQ-015 Three valid registers vA/vB/vC SHALL each load vVoted every edge.
REQ-016 outX SHALL be a dedicated per-replica voter output, majority(regA,regB,regC); outValidX SHALL be majority(vA,vB,vC); latency from input to output is exactly 1 cycle.
REQ-017 Replica X SHALL be in disagreement in a cycle when validX != vVoted, or when vVoted=1 and inX != dVoted.
REQ-018 Data disagreement SHALL be ignored when vVoted=0.
REQ-019 errCnt SHALL increment by exactly 1 per cycle with at least one replica in disagreement, regardless of how many replicas disagree.
REQ-020 errCnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 errFlag[X] SHALL be set on the edge after replica X disagrees and SHALL hold until errClr or reset.
REQ-022 errClr=1 SHALL take priority: errCnt=0 and errFlag=0 after the edge, even if a disagreement occurs in the same cycle.
REQ-023 A single corrupted register of any triplet SHALL NOT change any out*/outValid* value and SHALL be restored on the next edge.
REQ-024 A disagreement on all three replicas SHALL still yield the bitwise majority; no extra error state is defined.

Reset
REQ-025 rstn=0 SHALL immediately, without clk, force the following to 0: all reg*, all v*, outA/B/C, outValid*, errCnt and errFlag.
REQ-026 Reset asserted mid-stream SHALL discard in-flight data; the first edge after rstn rises SHALL behave as a normal cycle.

Verification
REQ-027 WIDTH=8, all valid=1, inA=inB=inC=8'h5A -> next cycle outA/B/C=8'h5A, outValid*=1, errCnt=0, errFlag=3'b000.
REQ-028 inA=8'h5A, inB=8'h5A, inC=8'hFF, valid* all 1 -> out*=8'h5A, errCnt=1, errFlag=3'b100.
REQ-029 Force regB to 8'h00 with valid*=0 and regA=regC=8'h5A -> out* stay 8'h5A, regB=8'h5A after one edge, errCnt unchanged.
REQ-030 CNT_W=2, persistent inC mismatch for 5 cycles -> errCnt 1,2,3,3,3; then errClr=1 with mismatch still present -> errCnt=0, errFlag=0.
REQ-031 validB=1, validA=validC=0, inB=8'hAA -> outValid*=0, data registers hold, errFlag=3'b010.
REQ-032 rstn pulsed low between edges while out*=8'h5A -> all outputs 0 immediately; following edge with valid data captures normally.
